bilinear_scaler_simd: RTL

- Next-generation N-lane SIMD bilinear scaler.
- Source and destination dimensions are set at run time, up to compile-time maxima. Both downscale and upscale are supported.
- Results stream out per batch over a valid/ready handshake with a lane mask; there is no full-frame output register.
- Sits between the frame buffer, which holds image_in, and the output writer/DMA. The interpolation datapath is internal.

---
 rtl/bilinear_scaler_simd.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/bilinear_scaler_simd.sv
// rtl/bilinear_scaler_simd.sv - N-lane SIMD bilinear scaler with run-time dimensions
// Streams one batch of up to N destination pixels per handshake; never spans rows.
module bilinear_scaler_simd #(
  parameter int MAX_SRC_H = 64,
  parameter int MAX_SRC_W = 64,
  parameter int MAX_DST_H = 64,
  parameter int MAX_DST_W = 64,
  parameter int N         = 4,
  parameter int FRAC      = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [6:0]                                 src_h,
  input  logic [6:0]                                 src_w,
  input  logic [6:0]                                 dst_h,
  input  logic [6:0]                                 dst_w,
  input  logic [MAX_SRC_H-1:0][MAX_SRC_W-1:0][7:0]   image_in,
  output logic                                       busy,
  output logic                                       cfg_err,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [N-1:0][7:0]                          out_pix,
  output logic [N-1:0]                               out_mask,
  output logic [6:0]                                 out_row,
  output logic [6:0]                                 out_col,
  output logic                                       out_last,
  output logic                                       done
);
  localparam int PW  = 24;
  localparam int AH  = (MAX_SRC_H > 1) ? $clog2(MAX_SRC_H) : 1;
  localparam int AW  = (MAX_SRC_W > 1) ? $clog2(MAX_SRC_W) : 1;
  localparam int ONE = 1 << FRAC;
  localparam int RND = 1 << (2 * FRAC - 1);

  typedef enum logic [2:0] {IDLE, DIV, PREP, CALC, OUT, DONE} state_t;
  state_t st, st_nxt;

  logic [6:0]               sh_r, sw_r, dh_r, dw_r;
  logic [15:0]              xq, yq, x_ratio, y_ratio;
  logic [6:0]               xrem, yrem;
  logic [3:0]               div_cnt;
  logic [6:0]               row, col;
  logic [N-1:0][7:0]        i00, i10, i01, i11;
  logic [N-1:0][FRAC-1:0]   wa;
  logic [FRAC-1:0]          wb;
  logic [N-1:0]             lmask;
  logic                     cfg_bad, row_end, last_row;
  logic [22:0]              xn, yn;

  // One restoring-division step: returns {remainder, shifted dividend/quotient}.
  function automatic logic [22:0] div_step(input logic [15:0] q, input logic [6:0] rem,
                                           input logic [6:0] d);
    logic [7:0] rs;
    rs = {rem, q[15]};
    if (rs >= {1'b0, d}) return {7'(rs - {1'b0, d}), q[14:0], 1'b1};
    return {7'(rs), q[14:0], 1'b0};
  endfunction

  assign xn = div_step(xq, xrem, dw_r - 7'd1);
  assign yn = div_step(yq, yrem, dh_r - 7'd1);

  assign cfg_bad = (src_h == 7'd0) || (int'(src_h) > MAX_SRC_H) ||
                   (src_w == 7'd0) || (int'(src_w) > MAX_SRC_W) ||
                   (dst_h == 7'd0) || (int'(dst_h) > MAX_DST_H) ||
                   (dst_w == 7'd0) || (int'(dst_w) > MAX_DST_W);
  assign row_end  = (8'(col) + 8'(N)) >= {1'b0, dw_r};
  assign last_row = row == (dh_r - 7'd1);
  assign busy     = st != IDLE;
  assign done     = st == DONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start && !cfg_bad) st_nxt = DIV;
      DIV:     if (div_cnt == 4'd15) st_nxt = PREP;
      PREP:    st_nxt = CALC;
      CALC:    st_nxt = OUT;
      OUT:     if (out_ready) st_nxt = out_last ? DONE : PREP;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // Neighbour fetch and weights for every lane of the current batch.
  logic [PW-1:0]          y_fp, x_fp;
  logic [6:0]             yl, xl;
  logic [AH-1:0]          yh;
  logic [AW-1:0]          xh;
  logic [7:0]             cx;
  logic [N-1:0][7:0]      p00, p10, p01, p11;
  logic [N-1:0][FRAC-1:0] pa;
  logic [N-1:0]           pmask;

  always_comb begin
    y_fp  = PW'(row) * PW'(y_ratio);
    yl    = 7'(y_fp >> FRAC);
    yh    = (yl + 7'd1 >= sh_r) ? AH'(sh_r - 7'd1) : AH'(yl + 7'd1);
    x_fp  = '0;
    xl    = '0;
    xh    = '0;
    cx    = '0;
    p00   = '0;
    p10   = '0;
    p01   = '0;
    p11   = '0;
    pa    = '0;
    pmask = '0;
    for (int k = 0; k < N; k++) begin
      cx       = 8'(col) + 8'(k);
      pmask[k] = cx < {1'b0, dw_r};
      x_fp     = PW'(cx) * PW'(x_ratio);
      xl       = 7'(x_fp >> FRAC);
      xh       = (xl + 7'd1 >= sw_r) ? AW'(sw_r - 7'd1) : AW'(xl + 7'd1);
      if (pmask[k]) begin
        p00[k] = image_in[AH'(yl)][AW'(xl)];
        p10[k] = image_in[AH'(yl)][xh];
        p01[k] = image_in[yh][AW'(xl)];
        p11[k] = image_in[yh][xh];
        pa[k]  = FRAC'(x_fp);
      end
    end
  end

  logic [31:0]       wa_c, wb_c, top, bot, acc;
  logic [N-1:0][7:0] cpix;

  always_comb begin
    wa_c = '0;
    top  = '0;
    bot  = '0;
    acc  = '0;
    cpix = '0;
    wb_c = 32'(ONE) - 32'(wb);
    for (int k = 0; k < N; k++) begin
      wa_c    = 32'(ONE) - 32'(wa[k]);
      top     = 32'(i00[k]) * wa_c + 32'(i10[k]) * 32'(wa[k]);
      bot     = 32'(i01[k]) * wa_c + 32'(i11[k]) * 32'(wa[k]);
      acc     = top * wb_c + bot * 32'(wb) + 32'(RND);
      cpix[k] = 8'(acc >> (2 * FRAC));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r <= '0; sw_r <= '0; dh_r <= '0; dw_r <= '0;
      xq <= '0; yq <= '0; xrem <= '0; yrem <= '0;
      x_ratio <= '0; y_ratio <= '0; div_cnt <= '0;
      row <= '0; col <= '0;
      i00 <= '0; i10 <= '0; i01 <= '0; i11 <= '0;
      wa <= '0; wb <= '0; lmask <= '0;
      cfg_err <= 1'b0; out_valid <= 1'b0; out_pix <= '0; out_mask <= '0;
      out_row <= '0; out_col <= '0; out_last <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (st)
        IDLE: if (start) begin
          sh_r    <= src_h;
          sw_r    <= src_w;
          dh_r    <= dst_h;
          dw_r    <= dst_w;
          cfg_err <= cfg_bad;
          xq      <= 16'(src_w - 7'd1) << FRAC;
          yq      <= 16'(src_h - 7'd1) << FRAC;
          xrem    <= '0;
          yrem    <= '0;
          div_cnt <= '0;
        end
        DIV: begin
          {xrem, xq} <= xn;
          {yrem, yq} <= yn;
          div_cnt    <= div_cnt + 4'd1;
          if (div_cnt == 4'd15) begin
            x_ratio <= (dw_r == 7'd1) ? 16'd0 : xn[15:0];
            y_ratio <= (dh_r == 7'd1) ? 16'd0 : yn[15:0];
            row     <= '0;
            col     <= '0;
          end
        end
        PREP: begin
          i00   <= p00;
          i10   <= p10;
          i01   <= p01;
          i11   <= p11;
          wa    <= pa;
          wb    <= FRAC'(y_fp);
          lmask <= pmask;
        end
        CALC: begin
          out_pix   <= cpix;
          out_mask  <= lmask;
          out_row   <= row;
          out_col   <= col;
          out_last  <= last_row && row_end;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (!out_last) begin
            if (row_end) begin
              col <= '0;
              row <= row + 7'd1;
            end else begin
              col <= col + 7'(N);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
